// File: rtl/serial_cfg_regs.sv
// serial_cfg_regs: loads NCH independent WIDTH-bit registers from a serial byte
// stream. A packet is one header byte (bit7=1, [6:0]=channel address) followed
// by NB=(WIDTH+6)/7 data bytes (bit7=0, 7 payload bits each, LSB group first).
// A header that arrives mid-packet flags an error and restarts reception, so
// the stream resynchronises without losing that byte. An idle gap of TIMEOUT
// cycles inside a packet drops it. Errors are pulsed on err_o and counted in
// err_cnt, which saturates at 255.
// Optional feature macro: SERIAL_CFG_CHECKSUM_EN appends a checksum byte (XOR of
// header[6:0] and every payload) that must match before the register is written.
`timescale 1ns/1ps

module serial_cfg_regs #(
    parameter int NCH     = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    output logic [NCH*WIDTH-1:0] regs_o,
    output logic [NCH-1:0]       upd_o,
    output logic                 err_o,
    output logic [7:0]           err_cnt,
    output logic                 busy
);

    localparam int NB = (WIDTH + 6) / 7;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(NB - 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [7:0]    NCH_B    = 8'(NCH);

`ifdef SERIAL_CFG_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

    state_t           state_reg, state_next;
    logic [6:0]       addr_reg, addr_next;
    logic [KW-1:0]    k_reg, k_next;
    logic [TW-1:0]    tmo_reg, tmo_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
`ifdef SERIAL_CFG_CHECKSUM_EN
    logic [6:0]       chk_reg, chk_next;
`endif
    logic             err_reg;
    logic [7:0]       err_cnt_reg;
    logic             busy_reg;

    logic [6:0]       payload;
    logic             hdr_ok;
    logic             wr_data;
    logic             clr_shadow;
    logic             commit;
    logic             err_evt;

    assign payload = rx_byte[6:0];
    assign hdr_ok  = ({1'b0, payload} < NCH_B);

    // Next-state decode: header/data classification, resync, checksum and timeout.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        k_next     = k_reg;
        clr_shadow = 1'b0;
        wr_data    = 1'b0;
        commit     = 1'b0;
        err_evt    = 1'b0;
`ifdef SERIAL_CFG_CHECKSUM_EN
        chk_next   = chk_reg;
`endif
        if (rx_valid) begin
            if (rx_byte[7]) begin
                // Any header inside a packet aborts it, then starts a new one.
                if (state_reg != S_IDLE) begin
                    err_evt = 1'b1;
                end
                if (hdr_ok) begin
                    state_next = S_DATA;
                    addr_next  = payload;
                    k_next     = '0;
                    clr_shadow = 1'b1;
`ifdef SERIAL_CFG_CHECKSUM_EN
                    chk_next   = payload;
`endif
                end else begin
                    err_evt    = 1'b1;
                    state_next = S_IDLE;
                end
            end else begin
                case (state_reg)
                    S_DATA: begin
                        wr_data = 1'b1;
                        k_next  = k_reg + KW'(1);
`ifdef SERIAL_CFG_CHECKSUM_EN
                        chk_next = chk_reg ^ payload;
                        if (k_reg == K_LAST) begin
                            state_next = S_CHK;
                        end
`else
                        if (k_reg == K_LAST) begin
                            commit     = 1'b1;
                            state_next = S_IDLE;
                        end
`endif
                    end
`ifdef SERIAL_CFG_CHECKSUM_EN
                    S_CHK: begin
                        if (payload == chk_reg) begin
                            commit = 1'b1;
                        end else begin
                            err_evt = 1'b1;
                        end
                        state_next = S_IDLE;
                    end
`endif
                    default: begin
                        // Stray data byte while idle: dropped without error.
                    end
                endcase
            end
        end else if ((TIMEOUT > 0) && (state_reg != S_IDLE) && (tmo_reg == TMO_LAST)) begin
            err_evt    = 1'b1;
            state_next = S_IDLE;
        end
    end

    // Idle-gap counter: restarts on every byte, runs only while a packet is open.
    always_comb begin
        tmo_next = '0;
        if (!(rx_valid || (state_next == S_IDLE) || (TIMEOUT == 0))) begin
            tmo_next = tmo_reg + TW'(1);
        end
    end

    // Shadow assembly: each 7-bit group keeps only the bits that fit in WIDTH.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_grp
            localparam int LO = 7 * gi;
            localparam int BW = ((WIDTH - LO) < 7) ? (WIDTH - LO) : 7;
            assign shadow_next[LO +: BW] =
                clr_shadow                            ? '0 :
                (wr_data && (k_reg == KW'(gi)))       ? payload[BW-1:0] :
                                                        shadow_reg[LO +: BW];
        end
    endgenerate

    // Packet FSM with registered error, counter and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            k_reg       <= '0;
            tmo_reg     <= '0;
            shadow_reg  <= '0;
`ifdef SERIAL_CFG_CHECKSUM_EN
            chk_reg     <= '0;
`endif
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            k_reg       <= k_next;
            tmo_reg     <= tmo_next;
            shadow_reg  <= shadow_next;
`ifdef SERIAL_CFG_CHECKSUM_EN
            chk_reg     <= chk_next;
`endif
            err_reg     <= err_evt;
            if (err_evt && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
            busy_reg    <= (state_next != S_IDLE);
        end
    end

    // Per-channel register and update strobe; only the addressed channel changes.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic             hit;
            logic [WIDTH-1:0] val_reg;
            logic             upd_bit_reg;

            assign hit = commit && (addr_reg == 7'(gi));

            // Commit writes the fully assembled shadow, including the final byte.
            always_ff @(posedge clk) begin
                if (rst) begin
                    val_reg     <= '0;
                    upd_bit_reg <= 1'b0;
                end else begin
                    upd_bit_reg <= hit;
                    if (hit) begin
                        val_reg <= shadow_next;
                    end
                end
            end

            assign regs_o[gi*WIDTH +: WIDTH] = val_reg;
            assign upd_o[gi]                 = upd_bit_reg;
        end
    endgenerate

    assign err_o   = err_reg;
    assign err_cnt = err_cnt_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_serial_cfg_regs.sv
// Testbench for serial_cfg_regs (NCH=4, WIDTH=32, TIMEOUT=16).
// Stimulus pushes expected update/error events into a queue; a monitor on the
// falling edge pops and compares whenever the DUT pulses upd_o or err_o.
`timescale 1ns/1ps

module tb_serial_cfg_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [127:0] regs_o;
    logic [3:0]   upd_o;
    logic         err_o;
    logic [7:0]   err_cnt;
    logic         busy;

    serial_cfg_regs #(.NCH(4), .WIDTH(32), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .regs_o   (regs_o),
        .upd_o    (upd_o),
        .err_o    (err_o),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        int         ch;
        logic [31:0] val;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pkt[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_errs = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic exp_upd(input int ch, input logic [31:0] val);
        exp_t e;
        e.is_err = 1'b0; e.ch = ch; e.val = val; e.cnt = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        if (exp_errs < 255) exp_errs++;
        e.is_err = 1'b1; e.ch = 0; e.val = '0; e.cnt = 8'(exp_errs);
        exp_q.push_back(e);
    endtask

    // Appends the checksum byte over pkt[start..end] when the feature is built in.
    task automatic add_chk(input int start);
`ifdef SERIAL_CFG_CHECKSUM_EN
        logic [6:0] x;
        x = '0;
        for (int i = start; i < pkt.size(); i++) x ^= pkt[i][6:0];
        pkt.push_back({1'b0, x});
`else
        if (start < 0) $display("note: negative start %0d", start);
`endif
    endtask

    // Sends pkt back-to-back (one byte per cycle), called and returning at a negedge.
    task automatic send_pkt();
        foreach (pkt[i]) begin
            rx_byte  = pkt[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        pkt.delete();
    endtask

    // Scoreboard monitor: one line per observed update/error transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ((upd_o != 4'b0) || err_o)) begin
            if ((upd_o != 4'b0) && err_o) begin
                checks++; errors++;
                $display("FAIL upd_err_overlap: upd_o=%b err_o=%b required not both", upd_o, err_o);
            end
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: upd_o=%b err_o=%b required no event", upd_o, err_o);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (e.is_err) begin
                    if (!err_o || (err_cnt !== e.cnt)) begin
                        errors++;
                        $display("FAIL err_event: err_o=%b err_cnt=%0d required err_o=1 err_cnt=%0d",
                                 err_o, err_cnt, e.cnt);
                    end else begin
                        $display("ok   err_event: err_cnt=%0d", err_cnt);
                    end
                end else begin
                    if ((upd_o !== (4'b0001 << e.ch)) || (regs_o[e.ch*32 +: 32] !== e.val)) begin
                        errors++;
                        $display("FAIL upd_event: upd_o=%b ch%0d=%h required upd_o=%b value=%h",
                                 upd_o, e.ch, regs_o[e.ch*32 +: 32], 4'b0001 << e.ch, e.val);
                    end else begin
                        $display("ok   upd_event: ch%0d=%h", e.ch, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst      = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_regs", regs_o, 128'h0);
        check("reset_upd", {124'h0, upd_o}, 128'h0);
        check("reset_err", {127'h0, err_o}, 128'h0);
        check("reset_errcnt", {120'h0, err_cnt}, 128'h0);
        check("reset_busy", {127'h0, busy}, 128'h0);

        // Basic load of channel 2.
        pkt = '{8'h82, 8'h78, 8'h2C, 8'h51, 8'h11, 8'h01};
        add_chk(0);
        exp_upd(2, 32'h12345678);
        send_pkt();
        repeat (2) @(negedge clk);
        check("t1_busy_idle", {127'h0, busy}, 128'h0);

`ifdef SERIAL_CFG_CHECKSUM_EN
        // Bad checksum: error, no write.
        pkt = '{8'h82, 8'h78, 8'h2C, 8'h51, 8'h11, 8'h01, 8'h16};
        exp_err();
        send_pkt();
        repeat (2) @(negedge clk);
        check("t2_ch2_kept", {96'h0, regs_o[64 +: 32]}, {96'h0, 32'h12345678});
`endif

        // Header inside a packet: error, then resync onto channel 1.
        pkt = '{8'h82, 8'h78, 8'h2C, 8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_err();
        add_chk(3);
        exp_upd(1, 32'h00000001);
        send_pkt();
        repeat (2) @(negedge clk);
        check("t3_ch2_kept", {96'h0, regs_o[64 +: 32]}, {96'h0, 32'h12345678});
        check("t3_errcnt", {120'h0, err_cnt}, 128'(exp_errs));

        // Out-of-range address, then stray data byte while idle.
        pkt = '{8'h85};
        exp_err();
        send_pkt();
        pkt = '{8'h33};
        send_pkt();
        repeat (3) @(negedge clk);
        check("t4_regs", regs_o, {32'h0, 32'h12345678, 32'h00000001, 32'h0});

        // Back-to-back packets; ch3 last byte carries bits above WIDTH that must vanish.
        pkt = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        add_chk(0);
        cyc = pkt.size();
        pkt.push_back(8'h83);
        pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h00);
        pkt.push_back(8'h00); pkt.push_back(8'h7F);
        add_chk(cyc);
        exp_upd(0, 32'h0000007F);
        exp_upd(3, 32'hF0000000);
        send_pkt();
        repeat (2) @(negedge clk);

        // Timeout after one data byte.
        pkt = '{8'h80, 8'h12};
        exp_err();
        send_pkt();
        check("t5_busy_open", {127'h0, busy}, 128'h1);
        cyc = 0;
        while (!err_o && (cyc < 40)) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_timeout_cycles", 128'(cyc), 128'd16);
        check("t5_busy_closed", {127'h0, busy}, 128'h0);
        repeat (6) @(negedge clk);
        pkt = '{8'h81, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h0F};
        add_chk(0);
        exp_upd(1, 32'hFFFFFFFF);
        send_pkt();
        repeat (2) @(negedge clk);
        check("t5_regs", regs_o, {32'hF0000000, 32'h12345678, 32'hFFFFFFFF, 32'h0000007F});

        // Reset mid-packet.
        pkt = '{8'h80, 8'h01, 8'h02, 8'h03};
        send_pkt();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_errs = 0;
        @(negedge clk);
        check("t6_regs_cleared", regs_o, 128'h0);
        check("t6_busy", {127'h0, busy}, 128'h0);
        check("t6_errcnt_cleared", {120'h0, err_cnt}, 128'h0);

        // Saturating error counter.
        for (int i = 0; i < 300; i++) begin
            pkt.push_back(8'hFF);
            exp_err();
        end
        send_pkt();
        repeat (3) @(negedge clk);
        check("t6_errcnt_sat", {120'h0, err_cnt}, 128'd255);
        check("t6_regs_still_zero", regs_o, 128'h0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
